// File: rtl/seg_scan_capture.sv
// Receive-side monitor for a multiplexed 4-digit active-low 7-segment display.
// Waits for each digit to settle, decodes it back to a nibble and rebuilds the shown value.
module seg_scan_capture #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an_en,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digits_valid,
    output logic        frame_done,
    output logic        seq_err,
    output logic        code_err,
    output logic [7:0]  err_count
);

    typedef enum logic [0:0] {SYNC = 1'b0, RUN = 1'b1} state_t;

    // Returns {ok, nibble}; ok=0 when the pattern is not a hex glyph.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = 5'h10;
            7'b1001111: r = 5'h11;
            7'b0010010: r = 5'h12;
            7'b0000110: r = 5'h13;
            7'b1001100: r = 5'h14;
            7'b0100100: r = 5'h15;
            7'b0100000: r = 5'h16;
            7'b0001111: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0000100: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b1100000: r = 5'h1B;
            7'b0110001: r = 5'h1C;
            7'b1000010: r = 5'h1D;
            7'b0110000: r = 5'h1E;
            7'b0111000: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // Returns {one_hot_low, slot}.
    function automatic logic [2:0] slot_of(input logic [3:0] a);
        logic [2:0] r;
        case (a)
            4'b1110: r = 3'b100;
            4'b1101: r = 3'b101;
            4'b1011: r = 3'b110;
            4'b0111: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [3:0]       an_q_r;
    logic [6:0]       seg_q_r;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;
    logic [1:0]       expect_r;

    logic       settle_s;
    logic [2:0] slot_info_s;
    logic [1:0] slot_s;
    logic [4:0] dec_s;
    logic       capture_s;
    logic       good_s;
    logic       seq_err_s;
    logic       code_err_s;
    logic       frame_done_s;

    // Classify the settled sample: capture, blanking, illegal anode or bad glyph.
    always_comb begin
        settle_s     = (cnt_r == CNT_W'(SETTLE_CYCLES - 1));
        slot_info_s  = slot_of(an_q_r);
        slot_s       = slot_info_s[1:0];
        dec_s        = seg_decode(seg_q_r);
        capture_s    = settle_s && slot_info_s[2];
        good_s       = capture_s && dec_s[4];
        code_err_s   = capture_s && !dec_s[4];
        seq_err_s    = 1'b0;
        frame_done_s = 1'b0;
        if (settle_s && !slot_info_s[2] && (an_q_r != 4'b1111)) begin
            seq_err_s = 1'b1;
        end else if (good_s && (state_r == RUN)) begin
            seq_err_s    = (slot_s != expect_r);
            frame_done_s = (slot_s == expect_r) && (slot_s == 2'd3);
        end else begin
            seq_err_s    = 1'b0;
            frame_done_s = 1'b0;
        end
    end

    // Input sampling, stability counter, sequence FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            an_q_r       <= 4'b1111;
            seg_q_r      <= 7'h7F;
            cnt_r        <= '0;
            state_r      <= SYNC;
            expect_r     <= 2'd0;
            digits       <= 16'h0000;
            digits_valid <= 4'h0;
            frame_done   <= 1'b0;
            seq_err      <= 1'b0;
            code_err     <= 1'b0;
            err_count    <= 8'h00;
        end else begin
            an_q_r     <= an_en;
            seg_q_r    <= seg;
            frame_done <= frame_done_s;
            seq_err    <= seq_err_s;
            code_err   <= code_err_s;
            if ({an_en, seg} != {an_q_r, seg_q_r}) begin
                cnt_r <= '0;
            end else if (cnt_r != '1) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if ((seq_err_s || code_err_s) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end else begin
                err_count <= err_count;
            end

            if (code_err_s) begin
                digits_valid[slot_s] <= 1'b0;
                state_r              <= SYNC;
            end else if (good_s) begin
                digits[{slot_s, 2'b00} +: 4] <= dec_s[3:0];
                digits_valid[slot_s]         <= 1'b1;
                case (state_r)
                    SYNC: begin
                        if (slot_s == 2'd0) begin
                            state_r  <= RUN;
                            expect_r <= 2'd1;
                        end else begin
                            state_r  <= SYNC;
                        end
                    end
                    RUN: begin
                        if (slot_s == expect_r) begin
                            expect_r <= expect_r + 2'd1;
                        end else if (slot_s == 2'd0) begin
                            expect_r <= 2'd1;
                        end else begin
                            state_r  <= SYNC;
                        end
                    end
                    default: state_r <= SYNC;
                endcase
            end else if (seq_err_s) begin
                state_r <= SYNC;
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule
